// File: rtl/arq_gbn_tx.sv
// Go-back-N ARQ transmitter: sequence-numbered retransmit buffer, cumulative acks,
// timeout-driven go-back and a sticky failure state after MAX_RETRY go-backs.
module arq_gbn_tx #(
  parameter int DATA_W    = 8,
  parameter int SEQ_W     = 3,
  parameter int WINDOW    = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_W-1:0]                    in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_W-1:0]                    tx_data,
  output logic [SEQ_W-1:0]                     tx_seq,
  output logic                                 tx_valid,
  input  logic                                 tx_ready,
  input  logic                                 ack_valid,
  input  logic [SEQ_W-1:0]                     ack_seq,
  output logic [SEQ_W-1:0]                     outstanding,
  output logic [$clog2(MAX_RETRY+1)-1:0]       retry_cnt,
  output logic                                 fail
);

  localparam int RW    = $clog2(MAX_RETRY + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << SEQ_W;

  localparam logic [SEQ_W-1:0] WIN  = SEQ_W'(WINDOW);
  localparam logic [TW-1:0]    TMO  = TW'(TIMEOUT);
  localparam logic [RW-1:0]    MAXR = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FAILED} state_t;

  state_t            state;
  logic [SEQ_W-1:0]  base_ptr, next_ptr, hi_ptr, tail_ptr;
  logic [TW-1:0]     timer;
  logic [RW-1:0]     retry;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr, hs, stalled, expired, ack_ok, fail_now;
  logic [SEQ_W-1:0]  fill, fly, ack_off, new_base, next_inc, next_hs, hi_hs;
  logic [SEQ_W-1:0]  n_base, n_next, n_hi, n_tail;
  logic [TW-1:0]     n_timer;
  logic [RW-1:0]     n_retry;

  assign fill        = tail_ptr - base_ptr;
  assign fly         = hi_ptr - base_ptr;
  assign in_ready    = (state != FAILED) && (fill < WIN);
  assign tx_valid    = (state == SEND);
  assign tx_seq      = next_ptr;
  // Buffer is never reset, so mask the read while nothing is offered.
  assign tx_data     = tx_valid ? mem[next_ptr] : '0;
  assign outstanding = fly;
  assign retry_cnt   = retry;
  assign fail        = (state == FAILED);

  assign wr       = in_valid && in_ready;
  assign hs       = tx_valid && tx_ready;
  assign stalled  = tx_valid && !tx_ready;
  assign expired  = (timer == TMO);
  assign ack_off  = ack_seq - base_ptr;
  assign ack_ok   = ack_valid && (state != FAILED) && (ack_off < fly);
  assign new_base = ack_seq + 1'b1;
  assign next_inc = next_ptr + 1'b1;
  assign next_hs  = hs ? next_inc : next_ptr;
  // Offsets from base never exceed WINDOW, so base-relative compares cannot wrap.
  assign hi_hs    = (hs && ((next_inc - base_ptr) > fly)) ? next_inc : hi_ptr;

  always_comb begin
    n_base   = base_ptr;
    n_next   = next_hs;
    n_hi     = hi_hs;
    n_tail   = wr ? tail_ptr + 1'b1 : tail_ptr;
    n_timer  = timer;
    n_retry  = retry;
    fail_now = 1'b0;
    if (state == FAILED) begin
      n_next   = next_ptr;
      n_hi     = hi_ptr;
      n_tail   = tail_ptr;
      fail_now = 1'b1;
    end else if (ack_ok) begin
      n_base  = new_base;
      if ((next_hs - base_ptr) < (new_base - base_ptr))
        n_next = new_base;
      n_timer = '0;
      n_retry = '0;
    end else if (expired) begin
      // A go-back waits for a stalled frame to complete; the timer holds meanwhile.
      if (retry == MAXR) begin
        fail_now = 1'b1;
      end else if (!stalled) begin
        n_next  = base_ptr;
        n_timer = '0;
        n_retry = retry + 1'b1;
      end
    end else if (hi_ptr != base_ptr) begin
      n_timer = timer + 1'b1;
    end else begin
      n_timer = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_ptr <= '0;
      next_ptr <= '0;
      hi_ptr   <= '0;
      tail_ptr <= '0;
      timer    <= '0;
      retry    <= '0;
    end else begin
      base_ptr <= n_base;
      next_ptr <= n_next;
      hi_ptr   <= n_hi;
      tail_ptr <= n_tail;
      timer    <= n_timer;
      retry    <= n_retry;
      if (fail_now)
        state <= FAILED;
      else if (n_next != n_tail)
        state <= SEND;
      else if (n_hi != n_base)
        state <= WAIT;
      else
        state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[tail_ptr] <= in_data;
  end

endmodule

// File: tb/tb_arq_gbn_tx.sv
// Randomised and directed bench for arq_gbn_tx against a queue-based go-back-N model
// that tracks absolute (unwrapped) frame counts.
module tb_arq_gbn_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic [2:0] tx_seq;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       ack_valid = 1'b0;
  logic [2:0] ack_seq = '0;
  logic [2:0] outstanding;
  logic [1:0] retry_cnt;
  logic       fail;

  arq_gbn_tx dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_seq(tx_seq), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .outstanding(outstanding),
    .retry_cnt(retry_cnt), .fail(fail)
  );

  always #5 clk = ~clk;

  localparam int W   = 4;
  localparam int TMO = 16;
  localparam int MR  = 3;

  typedef struct packed {
    logic       ir;
    logic       tv;
    logic [2:0] seq;
    logic [7:0] data;
    logic [2:0] outst;
    logic [1:0] retry;
    logic       fl;
  } st_t;

  typedef struct packed {
    logic [2:0] seq;
    logic [7:0] data;
  } fr_t;

  st_t stq[$];
  fr_t fq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: absolute frame indices, never wrapped.
  int         m_base, m_next, m_hi, m_tail, m_timer, m_retry;
  bit         m_fail;
  logic [7:0] m_mem[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_tv();
    return !m_fail && (m_next < m_tail);
  endfunction

  function automatic bit m_ir();
    return !m_fail && ((m_tail - m_base) < W);
  endfunction

  task automatic model_reset();
    m_base = 0; m_next = 0; m_hi = 0; m_tail = 0;
    m_timer = 0; m_retry = 0; m_fail = 0;
    m_mem.delete();
  endtask

  task automatic step(input logic iv, input logic [7:0] id, input logic tr,
                      input logic av, input logic [2:0] as);
    st_t e;
    fr_t f;
    bit  tv, ir;
    int  fly, d, n1, h1;
    @(negedge clk);
    in_valid = iv; in_data = id; tx_ready = tr; ack_valid = av; ack_seq = as;
    tv = m_tv();
    ir = m_ir();
    e.ir    = ir;
    e.tv    = tv;
    e.seq   = tv ? 3'(m_next) : 3'd0;
    e.data  = tv ? m_mem[m_next] : 8'd0;
    e.outst = 3'(m_hi - m_base);
    e.retry = 2'(m_retry);
    e.fl    = m_fail;
    stq.push_back(e);
    if (tv && tr) begin
      f.seq  = 3'(m_next);
      f.data = m_mem[m_next];
      fq.push_back(f);
    end
    if (!m_fail) begin
      fly = m_hi - m_base;
      d   = (int'(as) - (m_base % 8) + 8) % 8;
      n1  = m_next;
      h1  = m_hi;
      if (tv && tr) begin
        n1 = m_next + 1;
        if (n1 > h1) h1 = n1;
      end
      if (av && d < fly) begin
        m_base  = m_base + d + 1;
        if (n1 < m_base) n1 = m_base;
        m_timer = 0;
        m_retry = 0;
      end else if (m_timer == TMO) begin
        if (m_retry == MR) m_fail = 1;
        else if (!(tv && !tr)) begin
          n1 = m_base; m_timer = 0; m_retry++;
        end
      end else if (m_hi != m_base) m_timer++;
      else m_timer = 0;
      if (iv && ir) begin
        m_mem.push_back(id);
        m_tail++;
      end
      m_next = n1;
      m_hi   = h1;
    end
  endtask

  task automatic idle(input int n, input logic tr);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, tr, 1'b0, 3'd0);
  endtask

  task automatic ack_all();
    if (m_hi > m_base) step(1'b0, 8'h00, 1'b1, 1'b1, 3'(m_hi - 1));
    else idle(1, 1'b1);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_seq"}, 32'(tx_seq), 32'd0);
    chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    chk({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
  endtask

  // Asynchronous reset between clock edges, checked before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0; tx_ready = 1'b0; ack_valid = 1'b0;
    #1;
    reset_vals(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: per-cycle status against the model, plus frame scoreboard on each handshake.
  initial begin
    st_t e, a;
    fr_t f;
    forever begin
      @(negedge clk);
      #2;
      if (stq.size() > 0) begin
        e = stq.pop_front();
        a.ir    = in_ready;
        a.tv    = tx_valid;
        a.seq   = tx_valid ? tx_seq : 3'd0;
        a.data  = tx_valid ? tx_data : 8'd0;
        a.outst = outstanding;
        a.retry = retry_cnt;
        a.fl    = fail;
        chk("status", 32'(a), 32'(e));
      end
      if (tx_valid && tx_ready && !rst) begin
        if (fq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame: got seq %0d data %0h expected no frame", tx_seq, tx_data);
        end else begin
          f = fq.pop_front();
          chk("frame", {21'd0, tx_seq, tx_data}, {21'd0, f.seq, f.data});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, idx, sent;
    logic [7:0] bytes [6];
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_vals("por");
    rst = 1'b0;

    // Basic transfer
    step(1'b1, 8'hA0, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'hA1, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'hA2, 1'b1, 1'b0, 3'd0);
    idle(3, 1'b1);
    chk("basic_outstanding3", 32'(outstanding), 32'd3);
    step(1'b0, 8'h00, 1'b1, 1'b1, 3'd2);
    idle(2, 1'b1);
    chk("basic_outstanding0", 32'(outstanding), 32'd0);
    chk("basic_idle", 32'(tx_valid), 32'd0);

    // Window limit: six bytes held valid until accepted; partial ack mid-way
    for (int i = 0; i < 6; i++) bytes[i] = 8'hB0 + 8'(i);
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      k = (idx < 6 && m_ir()) ? 1 : 0;
      if (c == 8) chk("window_full", 32'(in_ready), 32'd0);
      step(idx < 6, idx < 6 ? bytes[idx] : 8'h00, 1'b1, c == 10, 3'(m_base + 1));
      idx += k;
    end
    ack_all();
    idle(2, 1'b1);

    // Timeout go-back then late ack once the oldest frame has been resent
    step(1'b1, 8'hC0, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'hC1, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'hC2, 1'b1, 1'b0, 3'd0);
    k = 0;
    while (!(m_retry == 1 && m_next == m_base + 1) && k < 60) begin
      idle(1, 1'b1);
      k++;
    end
    chk("goback_reached", 32'(k < 60), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 3'(m_base + 1));
    idle(3, 1'b1);
    ack_all();
    idle(2, 1'b1);

    // Go-back deferred by a stalled frame
    step(1'b1, 8'hD0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'hD1, 1'b0, 1'b0, 3'd0);
    idle(25, 1'b0);
    idle(8, 1'b1);
    ack_all();
    idle(2, 1'b1);

    // Failure: no acknowledgements at all
    step(1'b1, 8'hE0, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'hE1, 1'b1, 1'b0, 3'd0);
    idle(90, 1'b1);
    chk("fail_set", 32'(fail), 32'd1);
    chk("fail_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 3'(m_base));
    step(1'b0, 8'h00, 1'b1, 1'b1, 3'(m_hi - 1));
    idle(2, 1'b1);
    chk("fail_sticky", 32'(fail), 32'd1);
    do_reset("fail_rst");

    // Wrap with prompt acks, then a duplicate (stale) ack
    sent = 0;
    for (int c = 0; c < 80; c++) begin
      k = (sent < 20 && m_ir()) ? 1 : 0;
      step(sent < 20, 8'h40 + 8'(sent), 1'b1, m_hi > m_base, 3'(m_hi - 1));
      sent += k;
    end
    step(1'b1, 8'h77, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'h78, 1'b1, 1'b0, 3'd0);
    idle(1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 3'(m_base - 1));
    idle(2, 1'b1);
    ack_all();
    idle(2, 1'b1);

    // Reset in the middle of a transfer; first frame afterwards is seq 0
    step(1'b1, 8'h90, 1'b1, 1'b0, 3'd0);
    step(1'b1, 8'h91, 1'b0, 1'b0, 3'd0);
    do_reset("mid_rst");
    step(1'b1, 8'h5A, 1'b1, 1'b0, 3'd0);
    idle(2, 1'b1);
    ack_all();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if (m_fail) do_reset("rand_rst");
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
    end
    idle(3, 1'b1);
    @(negedge clk);
    #4;
    chk("frames_drained", 32'(fq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
